// File: rtl/input_capture_register_pkg.sv
// Shared definitions for the sticky input capture register.
package input_capture_register_pkg;

    // Capture qualifier: level-high or rising edge of the synchronized input.
    typedef enum logic {
        CAP_LEVEL = 1'b0,
        CAP_RISE  = 1'b1
    } cap_mode_e;

    // Deepest synchronizer chain supported.
    localparam int SYNC_STAGES_MAX = 4;

endpackage : input_capture_register_pkg

// File: rtl/input_capture_register_sync_chain.sv
// WIDTH-wide, STAGES-deep flop synchronizer. STAGES=0 passes the input through.
module input_capture_register_sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (STAGES == 0) begin : g_bypass
        // No flops: clock and reset are intentionally left unused here.
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign data_o = data_i;
    end else begin : g_chain
        logic [WIDTH-1:0] stage_q [STAGES];

        // Shift the raw input through the chain; reset clears every stage.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < STAGES; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= data_i;
                for (int i = 1; i < STAGES; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign data_o = stage_q[STAGES-1];
    end

endmodule : input_capture_register_sync_chain

// File: rtl/input_capture_register.sv
// Sticky input capture register: synchronizes raw strobes, qualifies them
// (level or rising edge) and latches each bit until clr_i.
module input_capture_register
    import input_capture_register_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] data_o
);

    // Depths beyond the supported maximum are clamped rather than built.
    localparam int STAGES_EFF = (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                                (SYNC_STAGES < 0)               ? 0 : SYNC_STAGES;
    localparam cap_mode_e MODE = (EDGE_MODE != 0) ? CAP_RISE : CAP_LEVEL;

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] data_q, data_d;

    input_capture_register_sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES_EFF)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (data_i),
        .data_o (sync_s)
    );

    // Qualify set events and compute the sticky next state; clear beats set.
    always_comb begin
        set_s  = sync_s;
        prev_d = sync_s;
        data_d = data_q;
        if (MODE == CAP_RISE) begin
            set_s = sync_s & ~prev_q;
        end
        if (clr_i) begin
            data_d = '0;
        end else begin
            data_d = data_q | set_s;
        end
    end

    // History resets high so an input already high at reset release is not an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '1;
            data_q <= '0;
        end else begin
            prev_q <= prev_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule : input_capture_register

// File: tb/tb_input_capture_register.sv
// Directed bench for input_capture_register across several parameterisations.
module tb_input_capture_register;

    logic       clk;
    logic       rst;
    // A: defaults (WIDTH=1, SYNC_STAGES=2, level)
    logic       data_a, clr_a;
    logic       out_a;
    // B: WIDTH=1, SYNC_STAGES=0, rising edge
    logic       data_b, clr_b;
    logic       out_b;
    // D: WIDTH=4, SYNC_STAGES=0, level
    logic [3:0] data_d, out_d;
    logic       clr_d;

    int n_checks = 0;
    int n_errors = 0;

    input_capture_register u_a (
        .clk_i(clk), .rst_i(rst), .data_i(data_a), .clr_i(clr_a), .data_o(out_a)
    );

    input_capture_register #(.WIDTH(1), .SYNC_STAGES(0), .EDGE_MODE(1)) u_b (
        .clk_i(clk), .rst_i(rst), .data_i(data_b), .clr_i(clr_b), .data_o(out_b)
    );

    input_capture_register #(.WIDTH(4), .SYNC_STAGES(0), .EDGE_MODE(0)) u_d (
        .clk_i(clk), .rst_i(rst), .data_i(data_d), .clr_i(clr_d), .data_o(out_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        data_a = 1'b0; clr_a = 1'b0;
        data_b = 1'b1; clr_b = 1'b0;   // high through reset: must not count as an edge
        data_d = 4'h0; clr_d = 1'b0;
        tick(); tick();
        check("reset_a", {31'd0, out_a}, 32'd0);
        check("reset_d", {28'd0, out_d}, 32'd0);
        rst = 1'b0;
        tick();
        check("rel_a", {31'd0, out_a}, 32'd0);
        check("rel_b_high", {31'd0, out_b}, 32'd0);
        tick(); tick();
        check("rel_b_hold", {31'd0, out_b}, 32'd0);

        // A: level capture with 2-stage latency, single-cycle pulse
        data_a = 1'b1;
        tick();                       // edge N samples the 1
        data_a = 1'b0;
        check("lat_a_N", {31'd0, out_a}, 32'd0);
        tick();
        check("lat_a_N1", {31'd0, out_a}, 32'd0);
        tick();
        check("lat_a_N2", {31'd0, out_a}, 32'd1);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("sticky_a", {31'd0, out_a}, 32'd1);
        end

        // A: clear while input held high, level re-sets after clear
        data_a = 1'b1;
        tick(); tick(); tick();
        clr_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_a", {31'd0, out_a}, 32'd0);
        end
        clr_a = 1'b0;
        tick();
        check("reset_after_clr_a", {31'd0, out_a}, 32'd1);

        // B: fresh rising edge captures
        data_b = 1'b0;
        tick();
        check("b_low", {31'd0, out_b}, 32'd0);
        data_b = 1'b1;
        tick();
        check("b_rise", {31'd0, out_b}, 32'd1);

        // B: clear while held high; no re-set without a new edge
        clr_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_b", {31'd0, out_b}, 32'd0);
        end
        clr_b = 1'b0;
        tick();
        check("b_no_reset1", {31'd0, out_b}, 32'd0);
        tick();
        check("b_no_reset2", {31'd0, out_b}, 32'd0);

        // B: rising edge coincides with clear -> discarded
        data_b = 1'b0;
        tick();
        data_b = 1'b1;
        clr_b  = 1'b1;
        tick();
        check("b_simul", {31'd0, out_b}, 32'd0);
        clr_b = 1'b0;
        tick();
        check("b_simul_after", {31'd0, out_b}, 32'd0);

        // D: independent bits, zero-stage capture
        data_d = 4'b0101;
        tick();
        check("d_0101", {28'd0, out_d}, 32'h5);
        data_d = 4'b1000;
        tick();
        check("d_1101", {28'd0, out_d}, 32'hD);
        data_d = 4'b0000;
        tick();
        check("d_hold", {28'd0, out_d}, 32'hD);
        clr_d = 1'b1;
        tick();
        check("d_clr", {28'd0, out_d}, 32'h0);
        clr_d = 1'b0;
        tick();
        check("d_after_clr", {28'd0, out_d}, 32'h0);

        // A: mid-operation reset with input high, then re-capture
        check("a_pre_rst", {31'd0, out_a}, 32'd1);
        rst = 1'b1;
        tick();
        check("a_rst", {31'd0, out_a}, 32'd0);
        rst = 1'b0;
        tick();
        check("a_recap1", {31'd0, out_a}, 32'd0);
        tick();
        check("a_recap2", {31'd0, out_a}, 32'd0);
        tick();
        check("a_recap3", {31'd0, out_a}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_input_capture_register
